cpu_int_controller: RTL and testbench

- CPU-side receiver for all interrupt request pulses: PPU VBlank/STAT, timer, serial, joypad.
- Holds the IF (0xFF0F) and IE (0xFFFF) registers, the IME flag and the EI one-instruction delay.
- Wakes HALT; resolves priority and vector during the CPU dispatch sequence.
- Sits between the request sources and the CPU core; register accesses arrive from the CPU bus decoder.

---
 rtl/cpu_int_controller_pkg.sv | 30 +++
 rtl/cpu_int_controller_if.sv | 41 ++++
 rtl/cpu_int_controller_prio_enc.sv | 29 ++
 rtl/cpu_int_controller.sv | 143 ++++++++++++++
 tb/tb_cpu_int_controller.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_int_controller_pkg.sv
// ============================================================
// cpu_int_pkg : shared constants and types for the interrupt controller
// Rev 1.0
// ============================================================
`default_nettype none

package cpu_int_pkg;

    localparam int INT_VBLANK = 0;
    localparam int INT_STAT   = 1;
    localparam int INT_TIMER  = 2;
    localparam int INT_SERIAL = 3;
    localparam int INT_JOYPAD = 4;

    localparam logic [7:0] VEC_BASE_DEF   = 8'h40;
    localparam int         VEC_STRIDE_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACKED  = 2'd1,
        VECTOR = 2'd2
    } int_state_t;

    function automatic logic [7:0] vec_addr(input logic [7:0] base, input int stride, input int idx);
        return 8'(int'(base) + stride * idx);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_int_controller_if.sv
// ============================================================
// cpu_int_controller_if : CPU-side request/register/dispatch bundle
// Rev 1.0
// ============================================================
`default_nettype none

interface cpu_int_controller_if #(
    parameter int NUM_SRC = 5
);
    logic               cpu_en;
    logic [NUM_SRC-1:0] irq_in;
    logic               if_wr;
    logic               ie_wr;
    logic [7:0]         wdata;
    logic [7:0]         if_rdata;
    logic [7:0]         ie_rdata;
    logic               ei_exec;
    logic               di_exec;
    logic               reti_exec;
    logic               instr_done;
    logic               int_ack;
    logic               vec_req;
    logic               int_pending;
    logic               int_req;
    logic [7:0]         int_vector;

    modport master (
        output cpu_en, irq_in, if_wr, ie_wr, wdata,
        output ei_exec, di_exec, reti_exec, instr_done, int_ack, vec_req,
        input  if_rdata, ie_rdata, int_pending, int_req, int_vector
    );

    modport slave (
        input  cpu_en, irq_in, if_wr, ie_wr, wdata,
        input  ei_exec, di_exec, reti_exec, instr_done, int_ack, vec_req,
        output if_rdata, ie_rdata, int_pending, int_req, int_vector
    );

endinterface

`default_nettype wire

// File: rtl/cpu_int_controller_prio_enc.sv
// ============================================================
// int_priority_enc : index of the lowest set bit of a request mask
// Rev 1.0
// ============================================================
`default_nettype none

module int_priority_enc #(
    parameter int NUM_SRC = 5,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_SRC-1:0] mask,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        valid = |mask;
        index = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_int_controller.sv
// ============================================================
// cpu_int_controller : IF/IE/IME registers, EI delay and dispatch FSM
// Rev 1.0
// ============================================================
`default_nettype none

module cpu_int_controller
    import cpu_int_pkg::*;
#(
    parameter int         NUM_SRC    = 5,
    parameter logic [7:0] VEC_BASE   = VEC_BASE_DEF,
    parameter int         VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic                  clk,
    input  logic                  n_rst,
    cpu_int_controller_if.slave   bus
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    int_state_t         r_state;
    int_state_t         w_state_nxt;
    logic [NUM_SRC-1:0] r_if;
    logic [NUM_SRC-1:0] w_if_nxt;
    logic [7:0]         r_ie;
    logic [7:0]         w_ie_nxt;
    logic               r_ime;
    logic               w_ime_nxt;
    logic               r_ei_delay;
    logic               w_ei_delay_nxt;
    logic [7:0]         r_vector;
    logic [7:0]         w_vector_nxt;

    logic [NUM_SRC-1:0] w_mask;
    logic               w_valid;
    logic [IDX_W-1:0]   w_idx;
    logic               w_dispatch;
    logic               w_ack_ok;

    assign w_mask     = r_ie[NUM_SRC-1:0] & r_if;
    assign w_dispatch = (r_state == ACKED) && bus.vec_req;
    assign w_ack_ok   = (r_state == IDLE) && bus.int_ack;

    int_priority_enc #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_prio (
        .mask  (w_mask),
        .valid (w_valid),
        .index (w_idx)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else if (bus.cpu_en) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.int_ack) w_state_nxt = ACKED;
            ACKED:   if (bus.vec_req) w_state_nxt = VECTOR;
            VECTOR:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Precedence rises down the block: write, then dispatch clear, then new requests.
    always_comb begin
        w_if_nxt     = r_if;
        w_vector_nxt = r_vector;
        if (bus.if_wr) begin
            w_if_nxt = bus.wdata[NUM_SRC-1:0];
        end
        if (w_dispatch) begin
            if (w_valid) begin
                w_if_nxt     = w_if_nxt & ~(NUM_SRC'(1) << w_idx);
                w_vector_nxt = vec_addr(VEC_BASE, VEC_STRIDE, int'(w_idx));
            end else begin
                w_vector_nxt = 8'h00;
            end
        end
        w_if_nxt = w_if_nxt | bus.irq_in;
    end

    assign w_ie_nxt = bus.ie_wr ? bus.wdata : r_ie;

    // ei_delay is tested before ei_exec sets it, so a same-cycle instr_done is not counted.
    always_comb begin
        w_ime_nxt      = r_ime;
        w_ei_delay_nxt = r_ei_delay;
        if (r_ei_delay && bus.instr_done) begin
            w_ime_nxt      = 1'b1;
            w_ei_delay_nxt = 1'b0;
        end
        if (bus.ei_exec) begin
            w_ei_delay_nxt = 1'b1;
        end
        if (bus.reti_exec) begin
            w_ime_nxt = 1'b1;
        end
        if (w_ack_ok) begin
            w_ime_nxt      = 1'b0;
            w_ei_delay_nxt = 1'b0;
        end
        if (bus.di_exec) begin
            w_ime_nxt      = 1'b0;
            w_ei_delay_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_if       <= '0;
            r_ie       <= 8'h00;
            r_ime      <= 1'b0;
            r_ei_delay <= 1'b0;
            r_vector   <= 8'h00;
        end else if (bus.cpu_en) begin
            r_if       <= w_if_nxt;
            r_ie       <= w_ie_nxt;
            r_ime      <= w_ime_nxt;
            r_ei_delay <= w_ei_delay_nxt;
            r_vector   <= w_vector_nxt;
        end
    end

    always_comb begin
        bus.if_rdata              = 8'hFF;
        bus.if_rdata[NUM_SRC-1:0] = r_if;
    end

    assign bus.ie_rdata    = r_ie;
    assign bus.int_pending = |w_mask;
    assign bus.int_req     = (|w_mask) && r_ime && (r_state == IDLE);
    assign bus.int_vector  = r_vector;

endmodule

`default_nettype wire

// File: tb/tb_cpu_int_controller.sv
// ============================================================
// tb_cpu_int_controller : directed scenarios plus randomized traffic vs a reference model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_cpu_int_controller;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    cpu_int_controller_if #(.NUM_SRC(5)) bus ();

    cpu_int_controller #(
        .NUM_SRC    (5),
        .VEC_BASE   (8'h40),
        .VEC_STRIDE (8)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: plain integers; phase 0 = waiting, 1 = acknowledged, 2 = vector delivered
    int m_if, m_ie, m_ime, m_delay, m_phase, m_vec;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_pending();
        return ((m_ie & m_if & 32'h1F) != 0) ? 1 : 0;
    endfunction

    function automatic int m_req();
        return (m_pending() == 1 && m_ime == 1 && m_phase == 0) ? 1 : 0;
    endfunction

    function automatic void model_reset();
        m_if = 0; m_ie = 0; m_ime = 0; m_delay = 0; m_phase = 0; m_vec = 0;
    endfunction

    function automatic void model_step();
        int nif, nime, ndelay, nphase, pend;
        if (!bus.cpu_en) return;
        nif = bus.if_wr ? (int'(bus.wdata) & 32'h1F) : m_if;
        if (m_phase == 1 && bus.vec_req) begin
            pend = m_ie & m_if & 32'h1F;
            m_vec = 0;
            for (int k = 4; k >= 0; k--) begin
                if (pend[k]) m_vec = 64 + 8 * k;
            end
            if (pend != 0) nif = nif & ~(1 << ((m_vec - 64) / 8));
        end
        nif = nif | int'(bus.irq_in);
        nime = m_ime; ndelay = m_delay;
        if (m_delay == 1 && bus.instr_done) begin nime = 1; ndelay = 0; end
        if (bus.ei_exec) ndelay = 1;
        if (bus.reti_exec) nime = 1;
        if (m_phase == 0 && bus.int_ack) begin nime = 0; ndelay = 0; end
        if (bus.di_exec) begin nime = 0; ndelay = 0; end
        nphase = m_phase;
        if (m_phase == 0 && bus.int_ack) nphase = 1;
        else if (m_phase == 1 && bus.vec_req) nphase = 2;
        else if (m_phase == 2) nphase = 0;
        if (bus.ie_wr) m_ie = int'(bus.wdata);
        m_if = nif; m_ime = nime; m_delay = ndelay; m_phase = nphase;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("if_rdata",    bus.if_rdata,    8'(32'hE0 | m_if));
            check("ie_rdata",    bus.ie_rdata,    8'(m_ie));
            check("int_pending", {7'd0, bus.int_pending}, 8'(m_pending()));
            check("int_req",     {7'd0, bus.int_req},     8'(m_req()));
            check("int_vector",  bus.int_vector,  8'(m_vec));
        end
    end

    task automatic clear_inputs();
        bus.irq_in = '0; bus.if_wr = 1'b0; bus.ie_wr = 1'b0; bus.wdata = 8'h00;
        bus.ei_exec = 1'b0; bus.di_exec = 1'b0; bus.reti_exec = 1'b0;
        bus.instr_done = 1'b0; bus.int_ack = 1'b0; bus.vec_req = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic wr_if(input logic [7:0] d);
        bus.if_wr = 1'b1; bus.wdata = d; cyc();
    endtask

    task automatic wr_ie(input logic [7:0] d);
        bus.ie_wr = 1'b1; bus.wdata = d; cyc();
    endtask

    initial begin
        clear_inputs();
        bus.cpu_en = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1 n_rst = 1'b1;
        chk_en = 1'b1;
        check("reset_if", bus.if_rdata, 8'hE0);
        check("reset_vec", bus.int_vector, 8'h00);

        // VBlank request with IME off, then RETI
        wr_ie(8'h01);
        bus.irq_in = 5'b00001; cyc();
        check("vblank_if", bus.if_rdata, 8'hE1);
        check("vblank_pending", {7'd0, bus.int_pending}, 8'h01);
        check("vblank_req_ime0", {7'd0, bus.int_req}, 8'h00);
        bus.reti_exec = 1'b1; cyc();
        check("reti_req", {7'd0, bus.int_req}, 8'h01);

        // Timer wins over joypad
        wr_ie(8'h1F);
        wr_if(8'h14);
        bus.int_ack = 1'b1; cyc();
        check("acked_req", {7'd0, bus.int_req}, 8'h00);
        bus.vec_req = 1'b1; cyc();
        check("timer_vec", bus.int_vector, 8'h50);
        check("timer_if", bus.if_rdata, 8'hF0);
        check("timer_req", {7'd0, bus.int_req}, 8'h00);
        bus.int_ack = 1'b1; cyc();
        bus.vec_req = 1'b1; cyc();
        check("ack_in_vector_vec", bus.int_vector, 8'h50);
        check("ack_in_vector_if", bus.if_rdata, 8'hF0);

        // EI delay
        bus.ei_exec = 1'b1; bus.instr_done = 1'b1; cyc();
        check("ei_first_done", {7'd0, bus.int_req}, 8'h00);
        bus.instr_done = 1'b1; cyc();
        check("ei_second_done", {7'd0, bus.int_req}, 8'h01);
        bus.int_ack = 1'b1; cyc();
        bus.vec_req = 1'b1; cyc();
        check("joypad_vec", bus.int_vector, 8'h60);
        check("joypad_if", bus.if_rdata, 8'hE0);
        cyc();
        wr_if(8'h10);
        bus.ei_exec = 1'b1; bus.instr_done = 1'b1; cyc();
        bus.di_exec = 1'b1; cyc();
        bus.instr_done = 1'b1; cyc();
        check("ei_di_req", {7'd0, bus.int_req}, 8'h00);

        // Cancel: IE cleared between ack and vector fetch
        wr_ie(8'h04);
        wr_if(8'h04);
        bus.reti_exec = 1'b1; cyc();
        bus.int_ack = 1'b1; cyc();
        wr_ie(8'h00);
        bus.vec_req = 1'b1; cyc();
        check("cancel_vec", bus.int_vector, 8'h00);
        check("cancel_if", bus.if_rdata, 8'hE4);
        cyc();

        // Collisions
        bus.if_wr = 1'b1; bus.wdata = 8'h00; bus.irq_in = 5'b01000; cyc();
        check("wr_vs_irq_if", bus.if_rdata, 8'hE8);
        wr_ie(8'h01);
        wr_if(8'h01);
        bus.reti_exec = 1'b1; cyc();
        bus.int_ack = 1'b1; cyc();
        bus.vec_req = 1'b1; bus.irq_in = 5'b00001; cyc();
        check("clr_vs_irq_vec", bus.int_vector, 8'h40);
        check("clr_vs_irq_if", bus.if_rdata, 8'hE1);
        cyc();

        // Asynchronous reset while acknowledged
        wr_if(8'h1F);
        wr_ie(8'h1F);
        bus.reti_exec = 1'b1; cyc();
        bus.int_ack = 1'b1; cyc();
        n_rst = 1'b0;
        model_reset();
        #1;
        check("rst_if", bus.if_rdata, 8'hE0);
        check("rst_ie", bus.ie_rdata, 8'h00);
        check("rst_req", {7'd0, bus.int_req}, 8'h00);
        check("rst_pending", {7'd0, bus.int_pending}, 8'h00);
        check("rst_vec", bus.int_vector, 8'h00);
        @(negedge clk);
        #1 n_rst = 1'b1;
        bus.vec_req = 1'b1; cyc();
        check("rst_idle_vec", bus.int_vector, 8'h00);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            bus.cpu_en     = ($urandom_range(0, 3) != 0);
            bus.irq_in     = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
            bus.if_wr      = ($urandom_range(0, 15) == 0);
            bus.ie_wr      = ($urandom_range(0, 11) == 0);
            bus.wdata      = 8'($urandom);
            bus.ei_exec    = ($urandom_range(0, 9) == 0);
            bus.di_exec    = ($urandom_range(0, 24) == 0);
            bus.reti_exec  = ($urandom_range(0, 14) == 0);
            bus.instr_done = ($urandom_range(0, 2) == 0);
            bus.int_ack    = (m_req() == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 19) == 0);
            bus.vec_req    = ($urandom_range(0, 2) == 0);
            cyc();
        end
        bus.cpu_en = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
